alu_exec_pipe: RTL and testbench
================================

Name: alu_exec_pipe

Overview:
- Execute-side consumer of the 3-bit alu_op code produced by the ALU control decode.
- Accepts operand pairs with an alu_op and tag over a valid/ready handshake.
- Computes the result in a 2-stage pipeline and returns result, zero flag (for beq/bne) and illegal-op flag over a second valid/ready handshake.
- Sits between the decode/register-read stage and writeback/branch-resolve logic. Sustains 1 op/cycle under full backpressure support.

Parameters:
- W, 32, operand/result width in bits.
- TAG_W, 4, width of the opaque in-order tag passed through unchanged.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  upstream presents an op.
- in_ready  output  1  block accepts the op this cycle.
- in_alu_op  input  3  operation code.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- in_tag  input  TAG_W  op identifier.
- out_valid  output  1  result presented.
- out_ready  input  1  downstream accepts the result.
- out_result  output  W  computed result.
- out_zero  output  1  out_result == 0.
- out_illegal  output  1  alu_op was not a defined code.
- out_tag  output  TAG_W  tag of this result.

Behaviour:
- Opcodes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT. Codes 011, 100 and 101 are illegal.
- ADD/SUB wrap modulo 2^W; no overflow flag.
- SLT is a signed compare. Result is 1 if $signed(a) < $signed(b), else 0. It is computed by direct signed compare, not from the SUB sign bit, so it stays correct on overflow.
- Illegal op: result = 0, out_zero = 1, out_illegal = 1. The op still flows through the pipe in order.
- Stage 1 (S1) registers alu_op, a, b and tag.
- Stage 2 (S2) registers out_result, out_zero, out_illegal and out_tag, computed from S1 contents.
- Accept rule: transfer in when in_valid && in_ready. Transfer out when out_valid && out_ready.
- s2_adv = !s2_valid || out_ready.
- s1_adv = s2_adv. S1 moves into S2 when s1_valid && s2_adv.
- in_ready = (!s1_valid || s2_adv) && !rst. This is combinational from out_ready; no path from in_valid to in_ready.
- Latency: an op accepted at edge N gives out_valid=1 after edge N+2 (visible in cycle N+2), provided out_ready was high.
- Throughput: 1/cycle with out_ready held high.
- Stall: while out_valid && !out_ready, all S2 outputs hold stable.
  - S1 holds if valid; in_ready=0 when S1 is also full.
  - Bubbles collapse: an empty S2 lets S1 advance even if out_ready=0.
- Ordering: strictly in order; tags emerge in acceptance order.
- Reset (sync, during the rst-high cycle):
  - s1_valid=0, out_valid=0, out_result=0, out_zero=0, out_illegal=0, out_tag=0; S1 data regs cleared to 0.
  - In-flight ops are discarded without being presented.
  - in_ready=0 while rst=1.
- Simultaneous accept-in and emit-out in one cycle with both stages full is allowed: each stage shifts one.
- out_valid never drops without a completed transfer, except on rst.

Decomposition:
- Package alu_pkg:
  - alu_op_t (logic [2:0]).
  - Constants ALU_AND=3'b000, ALU_OR=3'b001, ALU_ADD=3'b010, ALU_SUB=3'b110, ALU_SLT=3'b111.
  - Function is_legal_op.
  - The ALU control decode shares this package.
- Sub-module alu_core: purely combinational (op, a, b) -> (result, zero, illegal), instantiated between S1 and S2. All sequencing and handshake logic stays in alu_exec_pipe.

Test Plan:
- Basic ops, W=32, out_ready=1. Expected results: AND 0xF0F0_00FF & 0x0FF0_F00F -> 0x00F0_000F; OR same -> 0xFFF0_F0FF; ADD 0xFFFF_FFFF+1 -> 0, zero=1; SUB 5-7 -> 0xFFFF_FFFE. Each appears exactly 2 cycles after accept.
- SLT signed: a=0x8000_0000, b=0x7FFF_FFFF -> 1. a=0x7FFF_FFFF, b=0x8000_0000 -> 0 (overflow case). a=b=3 -> 0, zero=1.
- Illegal ops 011/100/101 with tags 1, 2, 3 -> result 0, zero=1, illegal=1, tags in order. A following ADD 2+2 -> 4, illegal=0.
- Backpressure: stream tags 0..7 back-to-back, hold out_ready=0 for 5 cycles.
  - Expect out_* stable with tag 0 and in_ready=0 after 2 accepts.
  - On release: tags 0..7 in order, no loss or duplication, 1/cycle.
- Bubble collapse: one op accepted, out_ready=0 from the start -> out_valid=1 two cycles later; in_ready stays 1 until S1 also fills.
- Reset mid-stream: both stages full, assert rst one cycle -> next cycle out_valid=0, out_result=0, in_ready=1. Old tags never appear; a new op completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcode definitions used by the ALU control decode and the execute pipe.
package alu_pkg;

    localparam int unsigned ALU_OP_W = 3;

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t ALU_AND = 3'b000;
    localparam alu_op_t ALU_OR  = 3'b001;
    localparam alu_op_t ALU_ADD = 3'b010;
    localparam alu_op_t ALU_SUB = 3'b110;
    localparam alu_op_t ALU_SLT = 3'b111;

    // True for the five defined opcodes; 011, 100 and 101 are reserved.
    function automatic logic is_legal_op(input alu_op_t op);
        case (op)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: op/a/b to result, zero and illegal flags.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  alu_op_t        op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [W-1:0]   result_c,
    output logic           zero_c,
    output logic           illegal_c
);

    // Operation select; SLT uses a true signed compare so overflow cannot flip it.
    always_comb begin
        result_c = '0;
        case (op)
            ALU_AND: result_c = a & b;
            ALU_OR:  result_c = a | b;
            ALU_ADD: result_c = a + b;
            ALU_SUB: result_c = a - b;
            ALU_SLT: result_c = W'($signed(a) < $signed(b));
            default: result_c = '0;
        endcase
    end

    assign zero_c    = (result_c == '0);
    assign illegal_c = !is_legal_op(op);

endmodule

// File: rtl/alu_exec_pipe.sv
// Two-stage ALU execute pipe with valid/ready handshakes on both sides.
module alu_exec_pipe
    import alu_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  alu_op_t          in_alu_op,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic             out_zero,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic             s1_valid;
    alu_op_t          s1_op;
    logic [W-1:0]     s1_a;
    logic [W-1:0]     s1_b;
    logic [TAG_W-1:0] s1_tag;

    logic             s2_adv;
    logic             s1_load;
    logic [W-1:0]     core_result;
    logic             core_zero;
    logic             core_illegal;

    // S2 can take new data when empty or when its current result is leaving.
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = (!s1_valid || s2_adv) && !rst;
    assign s1_load  = in_valid && in_ready;

    alu_core #(
        .W (W)
    ) u_core (
        .op        (s1_op),
        .a         (s1_a),
        .b         (s1_b),
        .result_c  (core_result),
        .zero_c    (core_zero),
        .illegal_c (core_illegal)
    );

    // S1 operand register: load on accept, otherwise drain into S2 when it advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_tag   <= '0;
        end else if (s1_load) begin
            s1_valid <= 1'b1;
            s1_op    <= in_alu_op;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_tag   <= in_tag;
        end else if (s2_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // S2 result register: holds while stalled, captures ALU output when S1 moves up.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_zero    <= 1'b0;
            out_illegal <= 1'b0;
            out_tag     <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result  <= core_result;
                out_zero    <= core_zero;
                out_illegal <= core_illegal;
                out_tag     <= s1_tag;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_pipe.sv
// Directed bench for alu_exec_pipe: op table plus backpressure, bubble and reset sequences.
module tb_alu_exec_pipe;

    localparam int unsigned W     = 32;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned NV    = 11;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_alu_op;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_result;
    logic             out_zero;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    typedef struct {
        logic [2:0]       op;
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic [TAG_W-1:0] tag;
        logic [W-1:0]     res;
        logic             zero;
        logic             ill;
    } vec_t;

    vec_t vecs [NV];

    int n_cmp = 0;
    int n_bad = 0;

    alu_exec_pipe #(
        .W     (W),
        .TAG_W (TAG_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_alu_op   (in_alu_op),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_illegal (out_illegal),
        .out_tag     (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [TAG_W-1:0] tag);
        in_valid  = v;
        in_alu_op = op;
        in_a      = a;
        in_b      = b;
        in_tag    = tag;
    endtask

    initial begin
        int next_tag;
        int exp_tag;
        int first_emit;
        int last_emit;
        int seen;

        vecs[0]  = '{3'b000, 32'hF0F0_00FF, 32'h0FF0_F00F, 4'd8,  32'h00F0_000F, 1'b0, 1'b0};
        vecs[1]  = '{3'b001, 32'hF0F0_00FF, 32'h0FF0_F00F, 4'd9,  32'hFFF0_F0FF, 1'b0, 1'b0};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 4'd10, 32'h0000_0000, 1'b1, 1'b0};
        vecs[3]  = '{3'b110, 32'h0000_0005, 32'h0000_0007, 4'd11, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4]  = '{3'b111, 32'h8000_0000, 32'h7FFF_FFFF, 4'd12, 32'h0000_0001, 1'b0, 1'b0};
        vecs[5]  = '{3'b111, 32'h7FFF_FFFF, 32'h8000_0000, 4'd13, 32'h0000_0000, 1'b1, 1'b0};
        vecs[6]  = '{3'b111, 32'h0000_0003, 32'h0000_0003, 4'd14, 32'h0000_0000, 1'b1, 1'b0};
        vecs[7]  = '{3'b011, 32'h1234_5678, 32'h0000_0001, 4'd1,  32'h0000_0000, 1'b1, 1'b1};
        vecs[8]  = '{3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2,  32'h0000_0000, 1'b1, 1'b1};
        vecs[9]  = '{3'b101, 32'h0000_00AA, 32'h0000_0055, 4'd3,  32'h0000_0000, 1'b1, 1'b1};
        vecs[10] = '{3'b010, 32'h0000_0002, 32'h0000_0002, 4'd4,  32'h0000_0004, 1'b0, 1'b0};

        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 3'b000, '0, '0, '0);

        // Reset state
        step();
        step();
        chk("rst_in_ready",    64'(in_ready),    64'd0);
        chk("rst_out_valid",   64'(out_valid),   64'd0);
        chk("rst_out_result",  64'(out_result),  64'd0);
        chk("rst_out_zero",    64'(out_zero),    64'd0);
        chk("rst_out_illegal", 64'(out_illegal), 64'd0);
        chk("rst_out_tag",     64'(out_tag),     64'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Op table, back-to-back with out_ready high: result appears two cycles after drive
        for (int i = 0; i < int'(NV) + 2; i++) begin
            if (i >= 2) begin
                chk($sformatf("v%0d_valid", i - 2),   64'(out_valid),   64'd1);
                chk($sformatf("v%0d_result", i - 2),  64'(out_result),  64'(vecs[i-2].res));
                chk($sformatf("v%0d_zero", i - 2),    64'(out_zero),    64'(vecs[i-2].zero));
                chk($sformatf("v%0d_illegal", i - 2), 64'(out_illegal), 64'(vecs[i-2].ill));
                chk($sformatf("v%0d_tag", i - 2),     64'(out_tag),     64'(vecs[i-2].tag));
            end else begin
                chk($sformatf("lat_c%0d_valid", i), 64'(out_valid), 64'd0);
            end
            if (i < int'(NV)) begin
                drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
                #1;
                chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
            end else begin
                drive(1'b0, 3'b000, '0, '0, '0);
            end
            step();
        end
        chk("drain_valid", 64'(out_valid), 64'd0);

        // Backpressure: stream tags 0..7, out_ready low for the first 5 cycles
        next_tag   = 0;
        exp_tag    = 0;
        first_emit = -1;
        last_emit  = -1;
        for (int c = 0; c < 40; c++) begin
            out_ready = (c >= 5);
            drive(next_tag < 8, 3'b010, W'(next_tag), '0, TAG_W'(next_tag));
            #1;
            if (c == 1) chk("bp_second_accept", 64'(in_ready), 64'd1);
            if (c >= 2 && c <= 4) begin
                chk($sformatf("bp_stall_c%0d_valid", c),    64'(out_valid),  64'd1);
                chk($sformatf("bp_stall_c%0d_tag", c),      64'(out_tag),    64'd0);
                chk($sformatf("bp_stall_c%0d_result", c),   64'(out_result), 64'd0);
                chk($sformatf("bp_stall_c%0d_in_ready", c), 64'(in_ready),   64'd0);
            end
            if (out_valid && out_ready) begin
                chk($sformatf("bp_emit%0d_tag", exp_tag),    64'(out_tag),    64'(exp_tag));
                chk($sformatf("bp_emit%0d_result", exp_tag), 64'(out_result), 64'(exp_tag));
                if (first_emit < 0) first_emit = c;
                last_emit = c;
                exp_tag++;
            end
            if (in_valid && in_ready) next_tag++;
            step();
        end
        drive(1'b0, 3'b000, '0, '0, '0);
        chk("bp_accepted",   64'(next_tag),               64'd8);
        chk("bp_emitted",    64'(exp_tag),                64'd8);
        chk("bp_first_emit", 64'(first_emit),             64'd5);
        chk("bp_emit_span",  64'(last_emit - first_emit), 64'd7);

        // Bubble collapse: S1 moves into an empty S2 even with out_ready low
        out_ready = 1'b0;
        drive(1'b1, 3'b010, 32'd5, 32'd0, 4'd5);
        #1;
        chk("bub_accept0", 64'(in_ready), 64'd1);
        step();
        drive(1'b0, 3'b000, '0, '0, '0);
        #1;
        chk("bub_c1_valid",    64'(out_valid), 64'd0);
        chk("bub_c1_in_ready", 64'(in_ready),  64'd1);
        step();
        chk("bub_c2_valid",    64'(out_valid), 64'd1);
        chk("bub_c2_tag",      64'(out_tag),   64'd5);
        chk("bub_c2_in_ready", 64'(in_ready),  64'd1);
        drive(1'b1, 3'b010, 32'd6, 32'd0, 4'd6);
        step();
        drive(1'b0, 3'b000, '0, '0, '0);
        #1;
        chk("bub_full_in_ready", 64'(in_ready), 64'd0);
        chk("bub_full_tag",      64'(out_tag),  64'd5);
        out_ready = 1'b1;
        #1;
        chk("bub_release_in_ready", 64'(in_ready), 64'd1);
        step();
        chk("bub_second_valid", 64'(out_valid), 64'd1);
        chk("bub_second_tag",   64'(out_tag),   64'd6);
        step();
        chk("bub_empty_valid", 64'(out_valid), 64'd0);

        // Reset mid-stream with both stages full
        out_ready = 1'b0;
        drive(1'b1, 3'b010, 32'd9, 32'd0, 4'd9);
        step();
        drive(1'b1, 3'b010, 32'd10, 32'd0, 4'd10);
        step();
        drive(1'b0, 3'b000, '0, '0, '0);
        #1;
        chk("mid_full_valid",    64'(out_valid), 64'd1);
        chk("mid_full_tag",      64'(out_tag),   64'd9);
        chk("mid_full_in_ready", 64'(in_ready),  64'd0);
        rst = 1'b1;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        step();
        rst = 1'b0;
        #1;
        chk("mid_after_valid",    64'(out_valid),  64'd0);
        chk("mid_after_result",   64'(out_result), 64'd0);
        chk("mid_after_tag",      64'(out_tag),    64'd0);
        chk("mid_after_in_ready", 64'(in_ready),   64'd1);
        out_ready = 1'b1;
        drive(1'b1, 3'b010, 32'd7, 32'd8, 4'd11);
        step();
        drive(1'b0, 3'b000, '0, '0, '0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) begin
                chk("mid_new_tag",    64'(out_tag),    64'd11);
                chk("mid_new_result", 64'(out_result), 64'd15);
                seen++;
            end
            step();
        end
        chk("mid_new_count", 64'(seen), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
